// File: rtl/perceptron_accum.sv
// rtl/perceptron_accum.sv - accumulates N_TERMS signed terms into a thresholded activation (PERCEPTRON_SAT_EN selects saturating adds)
module perceptron_accum #(
    parameter int IN_W    = 4,
    parameter int ACC_W   = 8,
    parameter int N_TERMS = 4,
    parameter logic signed [ACC_W-1:0] THRESH = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic             out_fire
);
    localparam int CNT_W = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_TERMS - 1);
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = ~ACC_MAX;

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t                  state, state_n;
    logic signed [ACC_W-1:0] acc, ext, sum_raw, acc_n;
    logic [CNT_W-1:0]        cnt;
    logic                    xfer, last;

    assign in_ready  = !rst && (state != DONE);
    assign out_valid = (state == DONE);
    assign xfer      = in_valid && in_ready;
    assign last      = (cnt == LAST);
    assign ext       = ACC_W'($signed(in_data));
    assign sum_raw   = acc + ext;

`ifdef PERCEPTRON_SAT_EN
    // Same-sign operands producing an opposite-sign result means the add overflowed.
    logic ovf;
    assign ovf   = (acc[ACC_W-1] == ext[ACC_W-1]) && (sum_raw[ACC_W-1] != acc[ACC_W-1]);
    assign acc_n = ovf ? (acc[ACC_W-1] ? ACC_MIN : ACC_MAX) : sum_raw;
`else
    assign acc_n = sum_raw;
`endif

    always_comb begin
        state_n = state;
        case (state)
            IDLE, ACCUM: begin
                if (xfer) begin
                    state_n = last ? DONE : ACCUM;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // The accumulator is cleared on the final term so IDLE always starts from zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            acc      <= '0;
            cnt      <= '0;
            out_acc  <= '0;
            out_fire <= 1'b0;
        end else begin
            state <= state_n;
            if (xfer) begin
                if (last) begin
                    acc      <= '0;
                    cnt      <= '0;
                    out_acc  <= acc_n;
                    out_fire <= (acc_n >= THRESH);
                end else begin
                    acc <= acc_n;
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_perceptron_accum.sv
// tb/tb_perceptron_accum.sv - randomized and directed checks of perceptron_accum against a behavioural model
module tb_perceptron_accum;
    localparam int NDUT = 3;
    localparam int MW [NDUT] = '{8, 5, 8};
    localparam int MN [NDUT] = '{4, 4, 1};

    logic clk = 1'b0;
    logic rst, in_valid, out_ready;
    logic [3:0] in_data;

    logic [NDUT-1:0] i_ready, o_valid, o_fire;
    logic [7:0] acc0, acc2;
    logic [4:0] acc1;
    int o_acc [NDUT];

    int checks = 0;
    int failures = 0;

    int  m_sum   [NDUT];
    int  m_cnt   [NDUT];
    int  m_racc  [NDUT];
    bit  m_hold  [NDUT];
    bit  m_rfire [NDUT];

    always #5 clk = ~clk;

    perceptron_accum #(.IN_W(4), .ACC_W(8), .N_TERMS(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(i_ready[0]), .in_data(in_data),
        .out_valid(o_valid[0]), .out_ready(out_ready), .out_acc(acc0), .out_fire(o_fire[0]));

    perceptron_accum #(.IN_W(4), .ACC_W(5), .N_TERMS(4)) dut5 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(i_ready[1]), .in_data(in_data),
        .out_valid(o_valid[1]), .out_ready(out_ready), .out_acc(acc1), .out_fire(o_fire[1]));

    perceptron_accum #(.IN_W(4), .ACC_W(8), .N_TERMS(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(i_ready[2]), .in_data(in_data),
        .out_valid(o_valid[2]), .out_ready(out_ready), .out_acc(acc2), .out_fire(o_fire[2]));

    always_comb begin
        o_acc[0] = int'($signed(acc0));
        o_acc[1] = int'($signed(acc1));
        o_acc[2] = int'($signed(acc2));
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic int add_w(input int a, input int b, input int w);
        int s, lo, hi;
        s  = a + b;
        hi = (1 << (w - 1)) - 1;
        lo = -(1 << (w - 1));
`ifdef PERCEPTRON_SAT_EN
        if (s > hi) s = hi;
        if (s < lo) s = lo;
`else
        s = s & ((1 << w) - 1);
        if (s > hi) s = s - (1 << w);
`endif
        return s;
    endfunction

    // Model: a neuron either gathers terms or holds one finished result.
    always @(posedge clk) begin
        for (int k = 0; k < NDUT; k++) begin
            automatic int s;
            if (rst) begin
                m_sum[k] <= 0; m_cnt[k] <= 0; m_hold[k] <= 1'b0;
                m_racc[k] <= 0; m_rfire[k] <= 1'b0;
            end else if (m_hold[k]) begin
                if (out_ready) m_hold[k] <= 1'b0;
            end else if (in_valid) begin
                s = add_w(m_sum[k], int'($signed(in_data)), MW[k]);
                if (m_cnt[k] + 1 == MN[k]) begin
                    m_hold[k] <= 1'b1; m_racc[k] <= s; m_rfire[k] <= (s >= 0);
                    m_sum[k] <= 0; m_cnt[k] <= 0;
                end else begin
                    m_sum[k] <= s; m_cnt[k] <= m_cnt[k] + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst !== 1'bx) begin
            for (int k = 0; k < NDUT; k++) begin
                chk($sformatf("dut%0d_in_ready", k), int'(i_ready[k]), int'(!rst && !m_hold[k]));
                chk($sformatf("dut%0d_out_valid", k), int'(o_valid[k]), int'(m_hold[k]));
                chk($sformatf("dut%0d_out_acc", k), o_acc[k], m_racc[k]);
                chk($sformatf("dut%0d_out_fire", k), int'(o_fire[k]), int'(m_rfire[k]));
            end
        end
    end

    task automatic push(input logic [3:0] d);
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("release_out_valid", int'(o_valid[0]), 0);
        chk("release_in_ready", int'(i_ready[0]), 1);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = 4'h0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", int'(o_valid[0]), 0);
        chk("rst_out_acc", int'(acc0), 8'h00);
        chk("rst_out_fire", int'(o_fire[0]), 0);
        chk("rst_in_ready", int'(i_ready[0]), 0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", int'(i_ready[0]), 1);

        push(4'b1001); push(4'b0110); push(4'b0011); push(4'b1111);
        chk("t2_out_valid", int'(o_valid[0]), 1);
        chk("t2_out_acc", int'(acc0), 8'h01);
        chk("t2_out_fire", int'(o_fire[0]), 1);
        release_result();

        push(4'b1001); push(4'b1001); push(4'b1001); push(4'b1001);
        for (int i = 0; i < 3; i++) begin
            chk("t3_out_acc", int'(acc0), 8'hE4);
            chk("t3_out_fire", int'(o_fire[0]), 0);
            chk("t3_in_ready", int'(i_ready[0]), 0);
            chk("t3_out_valid", int'(o_valid[0]), 1);
            in_valid = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
        release_result();

        push(4'b0111); push(4'b0111); push(4'b0111); push(4'b0111);
        chk("t4_acc8", int'(acc0), 8'h1C);
        chk("t4_fire8", int'(o_fire[0]), 1);
`ifdef PERCEPTRON_SAT_EN
        chk("t4_acc5", int'(acc1), 5'h0F);
        chk("t4_fire5", int'(o_fire[1]), 1);
`else
        chk("t4_acc5", int'(acc1), 5'h1C);
        chk("t4_fire5", int'(o_fire[1]), 0);
`endif
        release_result();

        push(4'b0110); push(4'b0110);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        push(4'b0001); push(4'b0001); push(4'b0001); push(4'b1110);
        chk("t5_out_acc", int'(acc0), 8'h01);
        chk("t5_out_fire", int'(o_fire[0]), 1);
        release_result();

        out_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            in_valid = (i != 2);
            in_data  = 4'($urandom);
            @(posedge clk); #1;
        end

        for (int i = 0; i < 600; i++) begin
            in_valid  = ($urandom_range(3) != 0);
            out_ready = ($urandom_range(2) != 0);
            in_data   = 4'($urandom);
            rst       = ($urandom_range(63) == 0);
            @(posedge clk); #1;
        end
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
